// File: rtl/dual_frame_axi_reader.sv
// Line-by-line AXI4 read master for two camera frame buffers (ch1 then ch2 per line).
// Optional FRAME_PINGPONG_EN: frame_start toggles a buffer select that adds FRAME_OFFSET to both bases.
module dual_frame_axi_reader #(
  parameter int CTRL_ADDR_WIDTH = 28,
  parameter int MEM_DQ_WIDTH = 32,
  parameter int BURST_LEN = 16,
  parameter int IMAGE_W = 1280,
  parameter int IMAGE_H = 720,
  parameter logic [CTRL_ADDR_WIDTH-1:0] CH1_BASE = '0,
  parameter logic [CTRL_ADDR_WIDTH-1:0] CH2_BASE = 28'h0100000,
  parameter logic [CTRL_ADDR_WIDTH-1:0] FRAME_OFFSET = 28'h0080000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         frame_start,
  input  logic                         line_req,
  input  logic                         buf_almost_full,
  output logic                         line_busy,
  output logic                         line_done,
  output logic                         line_overrun,
  output logic                         buf_wr_en,
  output logic [MEM_DQ_WIDTH*8-1:0]    buf_wr_data,
  output logic                         buf_wr_ch,
  output logic [CTRL_ADDR_WIDTH-1:0]   axi_araddr,
  output logic [3:0]                   axi_arid,
  output logic [3:0]                   axi_arlen,
  output logic [2:0]                   axi_arsize,
  output logic [1:0]                   axi_arburst,
  output logic                         axi_arvalid,
  input  logic                         axi_arready,
  output logic                         axi_rready,
  input  logic [MEM_DQ_WIDTH*8-1:0]    axi_rdata,
  input  logic                         axi_rvalid,
  input  logic                         axi_rlast,
  input  logic [3:0]                   axi_rid
);

  localparam int AW = CTRL_ADDR_WIDTH;
  localparam int LINE_BEATS = IMAGE_W / MEM_DQ_WIDTH;
  localparam int FIRST_BEATS = (LINE_BEATS > BURST_LEN) ? BURST_LEN : LINE_BEATS;
  localparam int OW = $clog2(LINE_BEATS + BURST_LEN + 1);
  localparam int LW = $clog2(IMAGE_H + 1);
  localparam logic [AW-1:0] LINE_STRIDE = AW'(LINE_BEATS * 8);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    DATA = 3'd2,
    NEXT = 3'd3,
    WAIT = 3'd4
  } state_t;

  state_t          state;
  logic            ch;
  logic [OW-1:0]   beat_off;
  logic [LW-1:0]   line_cnt;
  logic [AW-1:0]   line_addr;
  logic            pending;
  logic            abort;
  logic [AW-1:0]   bank_off;
  logic [OW-1:0]   remaining;
  logic [OW-1:0]   burst_beats;
  logic            more_beats;
  logic [AW-1:0]   next_addr;
  logic            unused_sig;

`ifdef FRAME_PINGPONG_EN
  logic frame_sel;
  assign bank_off   = frame_sel ? FRAME_OFFSET : '0;
  assign unused_sig = ^axi_rid;
`else
  assign bank_off   = '0;
  assign unused_sig = ^axi_rid ^ ^FRAME_OFFSET;
`endif

  // Geometry of the burst that starts at the current beat_off / ch.
  assign remaining   = OW'(LINE_BEATS) - beat_off;
  assign burst_beats = (remaining > OW'(BURST_LEN)) ? OW'(BURST_LEN) : remaining;
  assign more_beats  = (beat_off + OW'(BURST_LEN)) < OW'(LINE_BEATS);
  assign next_addr   = line_addr + (ch ? CH2_BASE : CH1_BASE) + bank_off
                       + (AW'(beat_off) << 3);

  assign axi_arsize  = 3'b101;
  assign axi_arburst = 2'b01;
  assign buf_wr_en   = axi_rvalid & axi_rready;
  assign buf_wr_data = buf_wr_en ? axi_rdata : '0;
  assign buf_wr_ch   = ch;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      ch           <= 1'b0;
      beat_off     <= '0;
      line_cnt     <= '0;
      line_addr    <= '0;
      pending      <= 1'b0;
      abort        <= 1'b0;
      line_busy    <= 1'b0;
      line_done    <= 1'b0;
      line_overrun <= 1'b0;
      axi_araddr   <= '0;
      axi_arid     <= '0;
      axi_arlen    <= '0;
      axi_arvalid  <= 1'b0;
      axi_rready   <= 1'b0;
`ifdef FRAME_PINGPONG_EN
      frame_sel    <= 1'b0;
`endif
    end else begin
      line_done <= 1'b0;

      // frame_start rewinds the line position at once; any in-flight burst still drains.
      if (frame_start) begin
        line_cnt     <= '0;
        line_addr    <= '0;
        line_overrun <= 1'b0;
        pending      <= 1'b0;
`ifdef FRAME_PINGPONG_EN
        frame_sel    <= ~frame_sel;
`endif
      end else if (line_req && line_busy) begin
        line_overrun <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (!frame_start && (line_req || pending)) begin
            if (buf_almost_full) begin
              pending <= 1'b1;
            end else begin
              pending     <= 1'b0;
              line_busy   <= 1'b1;
              ch          <= 1'b0;
              beat_off    <= '0;
              axi_araddr  <= line_addr + CH1_BASE + bank_off;
              axi_arlen   <= 4'(FIRST_BEATS - 1);
              axi_arid    <= 4'd1;
              axi_arvalid <= 1'b1;
              state       <= ADDR;
            end
          end
        end

        ADDR: begin
          if (frame_start) abort <= 1'b1;
          if (axi_arready) begin
            axi_arvalid <= 1'b0;
            axi_rready  <= 1'b1;
            state       <= DATA;
          end
        end

        DATA: begin
          if (frame_start) abort <= 1'b1;
          if (axi_rvalid && axi_rlast) begin
            axi_rready <= 1'b0;
            if (abort || frame_start) begin
              abort     <= 1'b0;
              line_busy <= 1'b0;
              state     <= IDLE;
            end else begin
              state <= NEXT;
            end
          end
        end

        NEXT: begin
          if (frame_start) begin
            line_busy <= 1'b0;
            state     <= IDLE;
          end else if (more_beats) begin
            beat_off <= beat_off + OW'(BURST_LEN);
            state    <= WAIT;
          end else if (!ch) begin
            ch       <= 1'b1;
            beat_off <= '0;
            state    <= WAIT;
          end else begin
            line_done <= 1'b1;
            line_busy <= 1'b0;
            state     <= IDLE;
            if (line_cnt == LW'(IMAGE_H - 1)) begin
              line_cnt  <= '0;
              line_addr <= '0;
            end else begin
              line_cnt  <= line_cnt + 1'b1;
              line_addr <= line_addr + LINE_STRIDE;
            end
          end
        end

        WAIT: begin
          if (frame_start) begin
            line_busy <= 1'b0;
            state     <= IDLE;
          end else if (!buf_almost_full) begin
            axi_araddr  <= next_addr;
            axi_arlen   <= 4'(burst_beats - 1'b1);
            axi_arid    <= ch ? 4'd2 : 4'd1;
            axi_arvalid <= 1'b1;
            state       <= ADDR;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
